// File: rtl/conv_window_ctrl_pkg.sv
// Shared types and sizing helpers for the convolution window controller.
// Build option CONV_CTRL_STATS_EN (used by conv_window_ctrl) enables the stall counter.
package conv_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FILL   = 3'd1,
    ST_STREAM = 3'd2,
    ST_DRAIN  = 3'd3,
    ST_DONE   = 3'd4
  } ctrl_state_e;

  localparam int unsigned DEF_KERNEL_SIZE = 3;
  localparam int unsigned DEF_ROW_SIZE    = 28;
  localparam int unsigned DEF_COL_SIZE    = 28;
  localparam int unsigned STALL_CNT_W     = 16;

  // Counter width for a modulo-n position; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  function automatic int unsigned windows_per_frame(input int unsigned k,
                                                    input int unsigned row_size,
                                                    input int unsigned col_size);
    return (row_size - k + 1) * (col_size - k + 1);
  endfunction

  localparam int unsigned DEF_COL_W   = cnt_width(DEF_ROW_SIZE);
  localparam int unsigned DEF_ROW_W   = cnt_width(DEF_COL_SIZE);
  localparam int unsigned DEF_WINDOWS = windows_per_frame(DEF_KERNEL_SIZE, DEF_ROW_SIZE,
                                                          DEF_COL_SIZE);

endpackage

// File: rtl/conv_window_ctrl_pos.sv
// Pixel position tracker: column wraps at ROW_SIZE-1 and carries into the row.
// Module name pos_counter; clear has priority over enable.
module pos_counter
  import conv_ctrl_pkg::*;
#(
  parameter int unsigned ROW_SIZE = DEF_ROW_SIZE,
  parameter int unsigned COL_SIZE = DEF_COL_SIZE,
  parameter int unsigned CW       = DEF_COL_W,
  parameter int unsigned RW       = DEF_ROW_W
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          en,
  output logic [CW-1:0] col,
  output logic [RW-1:0] row,
  output logic          last_col,
  output logic          last
);

  localparam logic [CW-1:0] COL_LAST = CW'(ROW_SIZE - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(COL_SIZE - 1);

  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  logic          last_row;

  assign last_col = (col_q == COL_LAST);
  assign last_row = (row_q == ROW_LAST);
  assign last     = last_col && last_row;

  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (clr) begin
      col_d = '0;
      row_d = '0;
    end else if (en) begin
      if (last_col) begin
        col_d = '0;
        row_d = last_row ? '0 : row_q + RW'(1);
      end else begin
        col_d = col_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q <= '0;
      row_q <= '0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
    end
  end

  assign col = col_q;
  assign row = row_q;

endmodule

// File: rtl/conv_window_ctrl.sv
// Streaming convolution window sequencer: gates pixels into the line buffer and flags valid windows.
// Build option: define CONV_CTRL_STATS_EN to count backpressure stall cycles on stall_count.
module conv_window_ctrl
  import conv_ctrl_pkg::*;
#(
  parameter int unsigned KERNEL_SIZE = DEF_KERNEL_SIZE,
  parameter int unsigned ROW_SIZE    = DEF_ROW_SIZE,
  parameter int unsigned COL_SIZE    = DEF_COL_SIZE
) (
  input  logic                            clock,
  input  logic                            resetn,
  input  logic                            start,
  input  logic                            pixel_valid,
  output logic                            pixel_ready,
  output logic                            lb_shift_en,
  output logic                            window_valid,
  input  logic                            conv_ready,
  output logic [cnt_width(COL_SIZE)-1:0]  out_row,
  output logic [cnt_width(ROW_SIZE)-1:0]  out_col,
  output logic                            busy,
  output logic                            frame_done,
  output logic [STALL_CNT_W-1:0]          stall_count
);

  localparam int unsigned CW = cnt_width(ROW_SIZE);
  localparam int unsigned RW = cnt_width(COL_SIZE);

  localparam logic [RW-1:0] FILL_LAST_ROW = RW'(KERNEL_SIZE - 2);
  localparam logic [RW-1:0] WIN_ROW_MIN   = RW'(KERNEL_SIZE - 1);
  localparam logic [CW-1:0] WIN_COL_MIN   = CW'(KERNEL_SIZE - 1);

  ctrl_state_e   state_q, state_d;
  logic          win_valid_q, win_valid_d;
  logic [RW-1:0] out_row_q, out_row_d;
  logic [CW-1:0] out_col_q, out_col_d;

  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic          last_col;
  logic          last_pix;
  logic          frame_start;
  logic          in_feed;
  logic          accept;
  logic          win_hit;

  assign frame_start = start && (state_q == ST_IDLE);
  assign in_feed     = (state_q == ST_FILL) || (state_q == ST_STREAM);
  // A held window blocks intake so the line buffer never shifts under it.
  assign pixel_ready = in_feed && (!win_valid_q || conv_ready);
  assign accept      = pixel_valid && pixel_ready;
  assign lb_shift_en = accept;
  assign win_hit     = accept && (row >= WIN_ROW_MIN) && (col >= WIN_COL_MIN);

  pos_counter #(
    .ROW_SIZE (ROW_SIZE),
    .COL_SIZE (COL_SIZE),
    .CW       (CW),
    .RW       (RW)
  ) u_pos (
    .clk      (clock),
    .rst_n    (resetn),
    .clr      (frame_start),
    .en       (accept),
    .col      (col),
    .row      (row),
    .last_col (last_col),
    .last     (last_pix)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (start) state_d = ST_FILL;
      end
      ST_FILL: begin
        if (accept && last_col && (row == FILL_LAST_ROW)) state_d = ST_STREAM;
      end
      ST_STREAM: begin
        if (accept && last_pix) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (!win_valid_q || conv_ready) state_d = ST_DONE;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_comb begin
    win_valid_d = win_valid_q;
    out_row_d   = out_row_q;
    out_col_d   = out_col_q;
    if (win_hit) begin
      win_valid_d = 1'b1;
      out_row_d   = row - WIN_ROW_MIN;
      out_col_d   = col - WIN_COL_MIN;
    end else if (conv_ready) begin
      win_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q     <= ST_IDLE;
      win_valid_q <= 1'b0;
      out_row_q   <= '0;
      out_col_q   <= '0;
    end else begin
      state_q     <= state_d;
      win_valid_q <= win_valid_d;
      out_row_q   <= out_row_d;
      out_col_q   <= out_col_d;
    end
  end

`ifdef CONV_CTRL_STATS_EN
  logic [STALL_CNT_W-1:0] stall_q, stall_d;

  always_comb begin
    stall_d = stall_q;
    if (frame_start) begin
      stall_d = '0;
    end else if (win_valid_q && !conv_ready && (stall_q != '1)) begin
      stall_d = stall_q + STALL_CNT_W'(1);
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      stall_q <= '0;
    end else begin
      stall_q <= stall_d;
    end
  end

  assign stall_count = stall_q;
`else
  assign stall_count = '0;
`endif

  assign window_valid = win_valid_q;
  assign out_row      = out_row_q;
  assign out_col      = out_col_q;
  assign busy         = (state_q != ST_IDLE);
  assign frame_done   = (state_q == ST_DONE);

endmodule

// File: tb/tb_conv_window_ctrl.sv
// Scoreboard bench for conv_window_ctrl at default parameters (3x3 kernel, 28x28 image).
module tb_conv_window_ctrl;

  localparam int NPIX = 784;
  localparam int NWIN = 676;
  localparam int WEDGE = 26;

  logic        clock = 1'b0;
  logic        resetn;
  logic        start;
  logic        pixel_valid;
  logic        pixel_ready;
  logic        lb_shift_en;
  logic        window_valid;
  logic        conv_ready;
  logic [4:0]  out_row;
  logic [4:0]  out_col;
  logic        busy;
  logic        frame_done;
  logic [15:0] stall_count;

  conv_window_ctrl #(
    .KERNEL_SIZE (3),
    .ROW_SIZE    (28),
    .COL_SIZE    (28)
  ) dut (
    .clock        (clock),
    .resetn       (resetn),
    .start        (start),
    .pixel_valid  (pixel_valid),
    .pixel_ready  (pixel_ready),
    .lb_shift_en  (lb_shift_en),
    .window_valid (window_valid),
    .conv_ready   (conv_ready),
    .out_row      (out_row),
    .out_col      (out_col),
    .busy         (busy),
    .frame_done   (frame_done),
    .stall_count  (stall_count)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    int r;
    int c;
  } win_t;
  win_t exp_q[$];

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input int act, input int req);
    n_checks++;
    if (act == req) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
  endtask

  // Monitor-side state, reset by the driver at each frame start.
  int acc_cnt, win_cnt, fd_cnt, fd_cyc, stall_cycles;
  bit first_seen;
  int hold_r, hold_c;

  // Backpressure driver state.
  bit stall_en, done34, donelast;
  int stall_left, rise_cyc;

  // Monitor: compares each window handshake against the scoreboard.
  always @(negedge clock) begin
    win_t w;
    if (resetn) begin
      if (window_valid && !first_seen) begin
        first_seen = 1'b1;
        check("first_window_accepts", acc_cnt, 59);
      end
      if (window_valid && conv_ready) begin
        win_cnt++;
        if (exp_q.size() == 0) begin
          check("window_unexpected", 1, 0);
        end else begin
          w = exp_q.pop_front();
          check("win_row", int'(out_row), w.r);
          check("win_col", int'(out_col), w.c);
        end
      end
      if (window_valid && !conv_ready) begin
        stall_cycles++;
        check("stall_pixel_ready", int'(pixel_ready), 0);
        check("stall_lb_shift_en", int'(lb_shift_en), 0);
        check("stall_hold_row", int'(out_row), hold_r);
        check("stall_hold_col", int'(out_col), hold_c);
      end
      if (frame_done) begin
        fd_cnt++;
        fd_cyc = cyc;
      end
      if (pixel_valid && pixel_ready) acc_cnt++;
    end
  end

  // conv_ready driver: stalls window (3,4) for 5 cycles and the last window for 3.
  initial begin
    conv_ready = 1'b1;
    stall_left = 0;
    rise_cyc   = -10;
    forever begin
      @(posedge clock);
      #1;
      if (stall_left > 0) begin
        stall_left--;
        if (stall_left == 0) begin
          conv_ready = 1'b1;
          rise_cyc   = cyc;
        end
      end else if (stall_en && window_valid && conv_ready) begin
        if (!done34 && out_row == 5'd3 && out_col == 5'd4) begin
          done34 = 1'b1; hold_r = 3; hold_c = 4;
          conv_ready = 1'b0; stall_left = 5;
        end else if (!donelast && out_row == 5'd25 && out_col == 5'd25) begin
          donelast = 1'b1; hold_r = 25; hold_c = 25;
          conv_ready = 1'b0; stall_left = 3;
        end
      end
    end
  end

  task automatic check_all_zero(input string tag);
    check({tag, "_pixel_ready"}, int'(pixel_ready), 0);
    check({tag, "_lb_shift_en"}, int'(lb_shift_en), 0);
    check({tag, "_window_valid"}, int'(window_valid), 0);
    check({tag, "_busy"}, int'(busy), 0);
    check({tag, "_frame_done"}, int'(frame_done), 0);
    check({tag, "_out_row"}, int'(out_row), 0);
    check({tag, "_out_col"}, int'(out_col), 0);
    check({tag, "_stall_count"}, int'(stall_count), 0);
  endtask

  // Starts a frame and feeds up to 'limit' pixels; returns the number of feed cycles used.
  task automatic run_frame(input bit toggle, input int limit, input bit stall,
                           input bit start_mid, output int iters);
    int sent;
    bit ph, mid_done;
    @(posedge clock); #1;
    acc_cnt = 0; win_cnt = 0; fd_cnt = 0; fd_cyc = -1; stall_cycles = 0;
    first_seen = 1'b0; done34 = 1'b0; donelast = 1'b0; stall_en = stall;
    exp_q.delete();
    for (int r = 0; r < WEDGE; r++)
      for (int c = 0; c < WEDGE; c++) exp_q.push_back('{r, c});
    start = 1'b1; pixel_valid = 1'b0;
    @(posedge clock); #1;
    start = 1'b0;
    sent = 0; iters = 0; ph = 1'b1; mid_done = 1'b0;
    while (sent < limit && iters < 4000) begin
      pixel_valid = toggle ? ph : 1'b1;
      ph = !ph;
      start = 1'b0;
      if (start_mid && !mid_done && sent == 400) begin
        start = 1'b1; mid_done = 1'b1;
      end
      @(negedge clock);
      if (pixel_valid && pixel_ready) sent++;
      iters++;
      @(posedge clock); #1;
    end
    pixel_valid = 1'b0; start = 1'b0;
    check("pixels_accepted", sent, limit);
  endtask

  task automatic finish_frame(input string tag);
    int k;
    k = 0;
    while (!frame_done && k < 200) begin
      @(negedge clock);
      k++;
    end
    check({tag, "_frame_done_seen"}, int'(frame_done), 1);
    check({tag, "_busy_in_done"}, int'(busy), 1);
    @(negedge clock);
    check({tag, "_frame_done_drop"}, int'(frame_done), 0);
    check({tag, "_busy_drop"}, int'(busy), 0);
    repeat (3) @(negedge clock);
    check({tag, "_frame_done_pulses"}, fd_cnt, 1);
    check({tag, "_window_count"}, win_cnt, NWIN);
    check({tag, "_scoreboard_empty"}, exp_q.size(), 0);
  endtask

  initial begin
    int iters;
    resetn = 1'b0; start = 1'b0; pixel_valid = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    check_all_zero("reset");
    resetn = 1'b1;

    // pixel_valid in IDLE is ignored
    pixel_valid = 1'b1;
    repeat (3) begin
      @(negedge clock);
      check("idle_pixel_ready", int'(pixel_ready), 0);
      check("idle_lb_shift_en", int'(lb_shift_en), 0);
      check("idle_busy", int'(busy), 0);
    end
    pixel_valid = 1'b0;

    // Frame 1: full rate, no backpressure
    run_frame(1'b0, NPIX, 1'b0, 1'b0, iters);
    check("f1_no_bubbles", iters, NPIX);
    finish_frame("f1");

    // Frame 2: stalls at window (3,4) and on the final window in DRAIN
    run_frame(1'b0, NPIX, 1'b1, 1'b0, iters);
    finish_frame("f2");
    check("f2_stall_cycles", stall_cycles, 8);
    check("f2_done_after_release", fd_cyc, rise_cyc + 1);
`ifdef CONV_CTRL_STATS_EN
    check("f2_stall_count", int'(stall_count), 8);
`else
    check("f2_stall_count", int'(stall_count), 0);
`endif

    // Frame 3: pixel_valid toggling, stray start mid-stream
    run_frame(1'b1, NPIX, 1'b0, 1'b1, iters);
    finish_frame("f3");

    // Frame 4: aborted by reset after 300 pixels
    run_frame(1'b0, 300, 1'b0, 1'b0, iters);
    check("f4_window_before_reset", int'(window_valid), 1);
    resetn = 1'b0;
    #2;
    check_all_zero("midreset");
    exp_q.delete();
    @(posedge clock); #1;
    resetn = 1'b1;

    // Frame 5: full frame after the aborted one
    run_frame(1'b0, NPIX, 1'b0, 1'b0, iters);
    finish_frame("f5");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed",
             n_pass, n_checks);
    $fatal(1, "watchdog timeout");
  end

endmodule
